dcache: RTL and testbench
=========================

# dcache

Two-way set-associative, write-back, write-allocate data cache. It serves the datapath's dcache port and fetches and evicts blocks through the memory controller's data port. On halt it writes every dirty block back to memory, then raises `flushed`. It sits between the pipeline MEM stage and the cache controller, alongside the icache, inside the caches wrapper.

## Interface
Parameters:
- SETS, 8, number of sets; index width = log2(SETS)
- WAYS, 2, fixed associativity; LRU is one bit per set

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- dcif.halt  in  1  datapath halted; start flush
- dcif.dmemREN  in  1  load request
- dcif.dmemWEN  in  1  store request
- dcif.datomic  in  1  treated as a plain access in this revision
- dcif.dmemaddr  in  32  byte address, word-aligned
- dcif.dmemstore  in  32  store data
- dcif.dhit  out  1  access completes this cycle
- dcif.dmemload  out  32  load data, valid when dhit
- dcif.flushed  out  1  all dirty data written back; sticky
- ccif.dwait  in  1  memory busy; request must be held
- ccif.dload  in  32  memory read data
- ccif.dREN  out  1  memory read request
- ccif.dWEN  out  1  memory write request
- ccif.daddr  out  32  memory word address
- ccif.dstore  out  32  memory write data

## Operation
- Address split: tag[31:6], idx[5:3], blkoff[2], bytoff[1:0]. Blocks are 2 words.
- Each frame holds valid, dirty, tag, and data[2]. Each set holds lru, which names the least-recently-used way.
- FSM states: IDLE, WB0, WB1, LD0, LD1, FLUSH, FWB0, FWB1, DONE.
- IDLE, checked in priority order:
  - halt → FLUSH.
  - REN or WEN with a tag match in a valid way → dhit=1.
    - A read drives dmemload from data[blkoff].
    - A write updates data[blkoff] and sets dirty on the edge.
    - lru ← other way.
    - If REN and WEN are both high, the write wins.
  - Miss: victim = lru way. If the victim is valid and dirty → WB0, else → LD0.
- WB0/WB1: dWEN=1, daddr={victim tag, idx, blkoff 0/1, 00}, dstore=victim word. Advance on !dwait. WB1 → LD0.
- LD0/LD1: dREN=1, daddr={req tag, idx, 0/1, 00}. On !dwait, capture dload into victim word.
  - LD1 → IDLE and writes victim tag, valid=1, dirty=0.
  - The retried access then hits in IDLE.
- FLUSH: a 4-bit counter walks {idx, way} from 0 to 15.
  - A valid, dirty frame goes to FWB0/FWB1, which are the same bus behaviour as WB0/WB1. The frame's dirty bit is cleared after FWB1, then the counter increments.
  - A clean frame increments the counter without a bus access.
  - When the counter wraps from 15 → DONE.
- DONE: flushed=1 and dhit=0. Held until reset; halt is no longer sampled.

## Timing
- Reset (async, immediate): state IDLE; all valid, dirty, and lru = 0; flush counter = 0.
- Outputs during reset: dhit, flushed, dREN, dWEN = 0; daddr, dstore, dmemload = 0.
- Hit latency: 0 cycles. dhit is combinational from the lookup in IDLE.
- Clean miss: 2 memory transactions; dhit arrives 1 cycle after the LD1 accept edge.
- Dirty miss: 4 transactions, in the order write, write, read, read.
- Memory handshake:
  - daddr, dstore, dREN, and dWEN are Moore outputs of the state, stable for as long as dwait=1.
  - Exactly one of dREN and dWEN is high in bus states; both are low elsewhere.
  - A transaction completes on the first edge where dwait=0.
- dhit is low in every non-IDLE state. The datapath holds REN, WEN, addr, and store until dhit.
- halt is sampled only in IDLE. An in-progress miss completes before the flush starts.
- Reset mid-transaction aborts immediately. No partial fill is marked valid.

## Structure
- The package `cpu_types_pkg` holds:
  - `dcachef_t`, the address breakdown: tag 26, idx 3, blkoff 1, bytoff 2
  - `dcache_frame_t`: valid, dirty, tag, data[2]
  - the `dcache_state_t` enum
- No sub-module is needed. Frames are register arrays, and the FSM, LRU, and flush counter are in one module.

## Test plan
- Read 0x100 after reset, dwait=1 for 2 cycles per access → LD0/LD1 reads 0x100/0x104; dhit next cycle with dmemload = mem[0x100]; a re-read hits in 0 cycles.
- Write 0xDEADBEEF to 0x104 (hit) → dhit same cycle; no bus activity; a later read of 0x104 returns 0xDEADBEEF.
- Fill both ways of idx 0 (0x000, 0x040), dirty 0x000, then access 0x080 → WB of 0x000/0x004, then LD of 0x080/0x084; way with 0x040 retained.
- Dirty frames at idx 2 and idx 5, then halt → exactly 4 writes in counter order; flushed=1 afterwards and stays high; dhit=0.
- REN=WEN=1 on hit → write performed.
- Reset during LD1 with dwait=1 → dREN drops at once; next read of that address misses.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the data cache: address breakdown, frame layout and controller states.
package cpu_types_pkg;

    typedef struct packed {
        logic [25:0] tag;
        logic [2:0]  idx;
        logic        blkoff;
        logic [1:0]  bytoff;
    } dcachef_t;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [25:0]      tag;
        logic [1:0][31:0] data;
    } dcache_frame_t;

    typedef enum logic [3:0] {
        StIdle, StWb0, StWb1, StLd0, StLd1, StFlush, StFwb0, StFwb1, StDone
    } dcache_state_t;

endpackage

// File: rtl/dcache.sv
// Two-way set-associative write-back, write-allocate data cache with LRU replacement
// and a halt-triggered flush of all dirty frames.
module dcache
    import cpu_types_pkg::*;
#(
    parameter int unsigned SETS = 8,
    parameter int unsigned WAYS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic        datomic,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    input  logic        dwait,
    input  logic [31:0] dload,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore
);

    dcache_frame_t frames [SETS][WAYS];
    logic [SETS-1:0] lru_q;
    dcache_state_t   state_q;
    logic            vway_q;
    logic [3:0]      cnt_q;

    dcachef_t      req;
    logic          hit0, hit1, hit_way, access;
    logic          flush_st;
    logic [2:0]    fidx;
    logic          fway;
    dcache_frame_t wbf, vict, hfr;
    logic          unused_bits;

    assign req      = dcachef_t'(dmemaddr);
    assign access   = dmemREN | dmemWEN;
    assign hit0     = frames[req.idx][0].valid && (frames[req.idx][0].tag == req.tag);
    assign hit1     = frames[req.idx][1].valid && (frames[req.idx][1].tag == req.tag);
    assign hit_way  = !hit0;
    assign hfr      = frames[req.idx][hit_way];
    assign vict     = frames[req.idx][lru_q[req.idx]];
    assign dhit     = (state_q == StIdle) && !halt && access && (hit0 || hit1);
    assign dmemload = (dhit && dmemREN) ? hfr.data[req.blkoff] : '0;
    assign flushed  = (state_q == StDone);

    // The flush walk addresses frames by counter ({idx, way}); a miss uses the held request.
    assign flush_st = (state_q == StFlush) || (state_q == StFwb0) || (state_q == StFwb1);
    assign fidx     = flush_st ? cnt_q[3:1] : req.idx;
    assign fway     = flush_st ? cnt_q[0] : vway_q;
    assign wbf      = frames[fidx][fway];

    assign unused_bits = ^{datomic, req.bytoff};

    always_comb begin
        dREN   = 1'b0;
        dWEN   = 1'b0;
        daddr  = '0;
        dstore = '0;
        case (state_q)
            StWb0, StFwb0: begin
                dWEN   = 1'b1;
                daddr  = {wbf.tag, fidx, 1'b0, 2'b00};
                dstore = wbf.data[0];
            end
            StWb1, StFwb1: begin
                dWEN   = 1'b1;
                daddr  = {wbf.tag, fidx, 1'b1, 2'b00};
                dstore = wbf.data[1];
            end
            StLd0: begin
                dREN  = 1'b1;
                daddr = {req.tag, req.idx, 1'b0, 2'b00};
            end
            StLd1: begin
                dREN  = 1'b1;
                daddr = {req.tag, req.idx, 1'b1, 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StIdle;
            vway_q  <= 1'b0;
            cnt_q   <= '0;
            lru_q   <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    frames[s][w] <= '0;
                end
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (halt) begin
                        state_q <= StFlush;
                    end else if (dhit) begin
                        if (dmemWEN) begin
                            frames[req.idx][hit_way].data[req.blkoff] <= dmemstore;
                            frames[req.idx][hit_way].dirty <= 1'b1;
                        end
                        lru_q[req.idx] <= ~hit_way;
                    end else if (access) begin
                        vway_q  <= lru_q[req.idx];
                        state_q <= (vict.valid && vict.dirty) ? StWb0 : StLd0;
                    end
                end
                StWb0: if (!dwait) state_q <= StWb1;
                StWb1: if (!dwait) state_q <= StLd0;
                StLd0: begin
                    // Frame is invalidated while half-filled so an abort never leaves stale data valid.
                    if (!dwait) begin
                        frames[req.idx][vway_q].data[0] <= dload;
                        frames[req.idx][vway_q].valid   <= 1'b0;
                        frames[req.idx][vway_q].dirty   <= 1'b0;
                        state_q <= StLd1;
                    end
                end
                StLd1: begin
                    if (!dwait) begin
                        frames[req.idx][vway_q].data[1] <= dload;
                        frames[req.idx][vway_q].tag     <= req.tag;
                        frames[req.idx][vway_q].valid   <= 1'b1;
                        frames[req.idx][vway_q].dirty   <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StFlush: begin
                    if (wbf.valid && wbf.dirty) begin
                        state_q <= StFwb0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == 4'd15) state_q <= StDone;
                    end
                end
                StFwb0: if (!dwait) state_q <= StFwb1;
                StFwb1: begin
                    if (!dwait) begin
                        frames[fidx][fway].dirty <= 1'b0;
                        cnt_q   <= cnt_q + 4'd1;
                        state_q <= (cnt_q == 4'd15) ? StDone : StFlush;
                    end
                end
                StDone: state_q <= StDone;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache.sv
// Randomized scoreboard bench for dcache: flat-memory golden model plus an LRU-list cache model.
module tb_dcache;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        halt = 1'b0;
    logic        dmemREN = 1'b0;
    logic        dmemWEN = 1'b0;
    logic        datomic = 1'b0;
    logic [31:0] dmemaddr = '0;
    logic [31:0] dmemstore = '0;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore;
    logic        dwait = 1'b1;
    logic [31:0] dload = '0;

    dcache dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .halt     (halt),
        .dmemREN  (dmemREN),
        .dmemWEN  (dmemWEN),
        .datomic  (datomic),
        .dmemaddr (dmemaddr),
        .dmemstore(dmemstore),
        .dhit     (dhit),
        .dmemload (dmemload),
        .flushed  (flushed),
        .dwait    (dwait),
        .dload    (dload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore)
    );

    always #5 CLK = ~CLK;

    typedef struct { bit we; logic [31:0] addr; logic [31:0] data; } txn_t;
    typedef struct { bit is_read; logic [31:0] data; } exp_t;
    typedef struct { logic [25:0] tag; bit dirty; } line_t;

    logic [31:0] bmem   [256];
    logic [31:0] golden [256];
    line_t       cset   [8][$];
    txn_t        bus_log[$];
    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          dly_min = 0;
    int          dly_max = 2;
    bit          hold_ld1 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Memory controller: random wait states, optional hold on the second fill word.
    initial begin
        int wcnt, cur_dly;
        logic [31:0] t_addr;
        txn_t t;
        wcnt = 0;
        cur_dly = 0;
        t_addr = '0;
        forever begin
            @(negedge CLK);
            if (!nRST || !(dREN || dWEN)) begin
                dwait = 1'b1;
                wcnt = 0;
            end else begin
                if (wcnt == 0) begin
                    cur_dly = $urandom_range(dly_max, dly_min);
                    t_addr = daddr;
                end
                if ((hold_ld1 && dREN && daddr[2]) || wcnt < cur_dly) begin
                    dwait = 1'b1;
                    wcnt++;
                end else begin
                    check("bus_stable", daddr, t_addr);
                    check("bus_onehot", {31'b0, dREN & dWEN}, 32'd0);
                    t.we = dWEN;
                    t.addr = daddr;
                    t.data = dstore;
                    if (dWEN) bmem[daddr[9:2]] = dstore;
                    else dload = bmem[daddr[9:2]];
                    bus_log.push_back(t);
                    dwait = 1'b0;
                    wcnt = 0;
                end
            end
        end
    end

    // Monitor: every dhit consumes one scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (nRST && dhit) begin
                if (exp_q.size() == 0) begin
                    check("spurious_dhit", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_read) check("load_data", dmemload, e.data);
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) cset[i].delete();
        for (int i = 0; i < 256; i++) golden[i] = bmem[i];
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        model_reset();
        @(posedge CLK);
        #1;
    endtask

    task automatic access(input bit re, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata);
        txn_t exp_tx[$];
        txn_t t;
        exp_t e;
        line_t l, v;
        int idx, pos, lat;
        bit phit;
        logic [2:0] idx3;
        idx3 = addr[5:3];
        idx = int'(idx3);
        pos = -1;
        for (int i = 0; i < cset[idx].size(); i++)
            if (cset[idx][i].tag == addr[31:6]) pos = i;
        phit = (pos >= 0);
        if (phit) begin
            l = cset[idx][pos];
            cset[idx].delete(pos);
            l.dirty = l.dirty | we;
            cset[idx].push_back(l);
        end else begin
            if (cset[idx].size() == 2) begin
                v = cset[idx].pop_front();
                if (v.dirty) begin
                    for (int b = 0; b < 2; b++) begin
                        t.we = 1'b1;
                        t.addr = {v.tag, idx3, b[0], 2'b00};
                        t.data = golden[t.addr[9:2]];
                        exp_tx.push_back(t);
                    end
                end
            end
            for (int b = 0; b < 2; b++) begin
                t.we = 1'b0;
                t.addr = {addr[31:6], idx3, b[0], 2'b00};
                t.data = '0;
                exp_tx.push_back(t);
            end
            l.tag = addr[31:6];
            l.dirty = we;
            cset[idx].push_back(l);
        end
        e.is_read = re && !we;
        e.data = golden[addr[9:2]];
        exp_q.push_back(e);
        if (we) golden[addr[9:2]] = wdata;

        bus_log.delete();
        dmemREN = re;
        dmemWEN = we;
        dmemaddr = addr;
        dmemstore = wdata;
        lat = 0;
        while (lat < 300) begin
            @(negedge CLK);
            if (dhit) break;
            lat++;
        end
        if (lat >= 300) begin
            check("access_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end else begin
            if (phit) check("hit_latency", lat, 32'd0);
            check("txn_count", bus_log.size(), exp_tx.size());
            for (int i = 0; i < exp_tx.size() && i < bus_log.size(); i++) begin
                check("txn_dir", {31'b0, bus_log[i].we}, {31'b0, exp_tx[i].we});
                check("txn_addr", bus_log[i].addr, exp_tx[i].addr);
                if (exp_tx[i].we) check("txn_wdata", bus_log[i].data, exp_tx[i].data);
            end
        end
        @(posedge CLK);
        #1;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
    endtask

    task automatic run_flush();
        int cyc;
        bus_log.delete();
        halt = 1'b1;
        cyc = 0;
        while (!flushed && cyc < 3000) begin
            @(negedge CLK);
            cyc++;
        end
        check("flushed", {31'b0, flushed}, 32'd1);
        halt = 1'b0;
    endtask

    initial begin
        int ndirty, cyc, prev_idx, mism, r;
        logic [31:0] a;
        logic [31:0] fl_addr [4];
        for (int i = 0; i < 256; i++) bmem[i] = $urandom;
        model_reset();

        #1 nRST = 1'b0;
        #12;
        check("rst_dhit", {31'b0, dhit}, 32'd0);
        check("rst_flushed", {31'b0, flushed}, 32'd0);
        check("rst_dren", {31'b0, dREN}, 32'd0);
        check("rst_dwen", {31'b0, dWEN}, 32'd0);
        check("rst_daddr", daddr, 32'd0);
        check("rst_dstore", dstore, 32'd0);
        check("rst_dmemload", dmemload, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        dly_min = 2;
        dly_max = 2;
        access(1, 0, 32'h100, 0);
        access(1, 0, 32'h100, 0);
        access(0, 1, 32'h104, 32'hDEADBEEF);
        access(1, 0, 32'h104, 0);
        check("store_readback", golden[32'h104 >> 2], 32'hDEADBEEF);
        access(1, 0, 32'h000, 0);
        access(0, 1, 32'h000, 32'h11112222);
        access(1, 0, 32'h040, 0);
        access(1, 0, 32'h080, 0);
        access(1, 0, 32'h040, 0);
        access(1, 1, 32'h040, 32'hCAFEF00D);
        access(1, 0, 32'h040, 0);

        // Abort a fill on its second word.
        dly_min = 0;
        dly_max = 2;
        hold_ld1 = 1'b1;
        dmemaddr = 32'h200;
        dmemREN = 1'b1;
        cyc = 0;
        while (!(dREN && daddr[2]) && cyc < 100) begin
            @(negedge CLK);
            cyc++;
        end
        check("ld1_reached", {31'b0, dREN && daddr[2]}, 32'd1);
        @(negedge CLK);
        #1 nRST = 1'b0;
        #1;
        check("abort_dren", {31'b0, dREN}, 32'd0);
        check("abort_daddr", daddr, 32'd0);
        dmemREN = 1'b0;
        hold_ld1 = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        model_reset();
        @(posedge CLK);
        #1;
        access(1, 0, 32'h200, 0);

        access(0, 1, 32'h028, 32'hA5A5_0028);
        access(0, 1, 32'h010, 32'h5A5A_0010);
        run_flush();
        fl_addr[0] = 32'h010;
        fl_addr[1] = 32'h014;
        fl_addr[2] = 32'h028;
        fl_addr[3] = 32'h02C;
        check("flush_count", bus_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < bus_log.size(); i++) begin
            check("flush_dir", {31'b0, bus_log[i].we}, 32'd1);
            check("flush_addr", bus_log[i].addr, fl_addr[i]);
            check("flush_data", bus_log[i].data, golden[fl_addr[i][9:2]]);
        end
        dmemaddr = 32'h010;
        dmemREN = 1'b1;
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("done_dhit", {31'b0, dhit}, 32'd0);
            check("done_flushed", {31'b0, flushed}, 32'd1);
        end
        dmemREN = 1'b0;
        halt = 1'b0;

        do_reset();
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(3);
            a = {22'b0, 8'($urandom_range(255)), 2'b00};
            access(r != 2, r >= 2, a, $urandom);
        end
        ndirty = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < cset[i].size(); j++)
                if (cset[i][j].dirty) ndirty++;
        @(posedge CLK);
        #1;
        run_flush();
        check("rand_flush_count", bus_log.size(), 2 * ndirty);
        prev_idx = 0;
        for (int i = 0; i < bus_log.size(); i++) begin
            check("rand_flush_data", bus_log[i].data, golden[bus_log[i].addr[9:2]]);
            check("rand_flush_order", {31'b0, int'(bus_log[i].addr[5:3]) >= prev_idx}, 32'd1);
            prev_idx = int'(bus_log[i].addr[5:3]);
        end
        mism = 0;
        for (int i = 0; i < 256; i++) if (bmem[i] !== golden[i]) mism++;
        check("mem_coherent", mism, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
